// File: rtl/graph_data_response_fifo.sv
// rtl/graph_data_response_fifo.sv - circular response FIFO between the demux READ_GRAPH_DATA lane and the PageRank PULL datapath
//
// Purpose:
//   Buffers valid-only (no backpressure) response words from the demux lane.
//   Hands them out under a request/valid pop protocol with one cycle of latency.
//   fifo_almost_full rises early enough that the read issuer can stop before
//   in-flight responses overflow the buffer.
//
// Optional feature:
//   GRAPH_DATA_FIFO_STATS_EN - when defined, builds accepted push/pop counters.
//   When undefined, push_count and pop_count are tied to zero.
//
// Ports:
//   clock            in   system clock, rising edge
//   rstn             in   asynchronous active-low reset
//   data_in          in   response word, bit order [0:DATA_WIDTH-1]
//   data_in_valid    in   push strobe, one word per cycle
//   data_out_ready   in   pop request
//   data_out         out  popped word, registered
//   data_out_valid   out  one-cycle pulse per accepted pop
//   fifo_empty       out  count == 0
//   fifo_full        out  count == DEPTH
//   fifo_almost_full out  count >= DEPTH - ALMOST_FULL_MARGIN
//   overflow_error   out  sticky, a push was dropped
//   push_count       out  accepted pushes (stats build only)
//   pop_count        out  accepted pops (stats build only)
module graph_data_response_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic [0:DATA_WIDTH-1] data_in,
  input  logic                  data_in_valid,
  input  logic                  data_out_ready,
  output logic [0:DATA_WIDTH-1] data_out,
  output logic                  data_out_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_almost_full,
  output logic                  overflow_error,
  output logic [31:0]           push_count,
  output logic [31:0]           pop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - ALMOST_FULL_MARGIN);

  logic [0:DATA_WIDTH-1] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  pop_acc;
  logic                  push_acc;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is popped; an empty FIFO ignores the pop even with a push pending.
  assign pop_acc  = data_out_ready && (count != '0);
  assign push_acc = data_in_valid && ((count != FULL_LVL) || pop_acc);

  always_comb begin
    count_next = count;
    if (push_acc && !pop_acc) begin
      count_next = count + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_next = count - 1'b1;
    end
  end

  // Storage is not reset: a reset only discards entries by clearing pointers.
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      data_out         <= '0;
      data_out_valid   <= 1'b0;
      fifo_empty       <= 1'b1;
      fifo_full        <= 1'b0;
      fifo_almost_full <= 1'b0;
      overflow_error   <= 1'b0;
    end else begin
      count          <= count_next;
      data_out_valid <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (data_in_valid && !push_acc) begin
        overflow_error <= 1'b1;
      end
      // Flags come from the next-state count so they line up with count.
      fifo_empty       <= (count_next == '0);
      fifo_full        <= (count_next == FULL_LVL);
      fifo_almost_full <= (count_next >= AF_LVL);
    end
  end

`ifdef GRAPH_DATA_FIFO_STATS_EN
  logic [31:0] push_cnt_q;
  logic [31:0] pop_cnt_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
    end else begin
      if (push_acc) begin
        push_cnt_q <= push_cnt_q + 32'd1;
      end
      if (pop_acc) begin
        pop_cnt_q <= pop_cnt_q + 32'd1;
      end
    end
  end

  assign push_count = push_cnt_q;
  assign pop_count  = pop_cnt_q;
`else
  assign push_count = 32'd0;
  assign pop_count  = 32'd0;
`endif

endmodule

// File: tb/tb_graph_data_response_fifo.sv
// tb/tb_graph_data_response_fifo.sv - directed self-checking bench for graph_data_response_fifo
module tb_graph_data_response_fifo;

  logic        clock;
  logic        rstn;
  logic [0:31] data_in;
  logic        data_in_valid;
  logic        data_out_ready;
  logic [0:31] data_out;
  logic        data_out_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        overflow_error;
  logic [31:0] push_count;
  logic [31:0] pop_count;

  int checks;
  int errors;

  graph_data_response_fifo #(
    .DATA_WIDTH(32),
    .DEPTH(16),
    .ALMOST_FULL_MARGIN(4)
  ) dut (
    .clock(clock),
    .rstn(rstn),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_out_ready(data_out_ready),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .overflow_error(overflow_error),
    .push_count(push_count),
    .pop_count(pop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    rstn           = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 1; i <= n; i++) begin
      data_in       = base + i;
      data_in_valid = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_out valid=%b data=%h required valid=0 data=0", data_out_valid, data_out);
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_almost_full !== 1'b0 || overflow_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags e=%b f=%b af=%b ov=%b required 1 0 0 0", fifo_empty, fifo_full, fifo_almost_full, overflow_error);
    end
    checks++;
    if (push_count !== 32'd0 || pop_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts push=%0d pop=%0d required 0 0", push_count, pop_count);
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      data_in       = i;
      data_in_valid = 1'b1;
      tick();
      checks++;
      if (fifo_almost_full !== (i >= 12) || fifo_full !== (i == 16) || fifo_empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_flags n=%0d af=%b f=%b e=%b required af=%b f=%b e=0", i, fifo_almost_full, fifo_full, fifo_empty, (i >= 12), (i == 16));
      end
    end
    data_in_valid = 1'b0;
    checks++;
    if (overflow_error !== 1'b0) begin
      errors++;
      $display("FAIL fill_overflow got %b required 0", overflow_error);
    end
  endtask

  task automatic test_drain;
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle valid=%b required 0", data_out_valid);
    end
    for (int i = 1; i <= 16; i++) begin
      data_out_ready = 1'b1;
      tick();
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== 32'(i)) begin
        errors++;
        $display("FAIL drain_word n=%0d valid=%b data=%h required valid=1 data=%h", i, data_out_valid, data_out, i);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty e=%b f=%b required e=1 f=0", fifo_empty, fifo_full);
    end
    tick();
    data_out_ready = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== 32'h10) begin
      errors++;
      $display("FAIL drain_extra valid=%b data=%h required valid=0 data=00000010", data_out_valid, data_out);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    push_words(32'h100, 16);
    data_in       = 32'hDEAD;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if (overflow_error !== 1'b1 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag ov=%b f=%b required ov=1 f=1", overflow_error, fifo_full);
    end
    data_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL ovf_drain n=%0d valid=%b data=%h required valid=1 data=%h", i, data_out_valid, data_out, 32'h100 + 32'(i));
      end
    end
    data_out_ready = 1'b0;
    tick();
    checks++;
    if (overflow_error !== 1'b1 || fifo_empty !== 1'b1 || data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky ov=%b e=%b valid=%b required ov=1 e=1 valid=0", overflow_error, fifo_empty, data_out_valid);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] exp;
    do_reset();
    push_words(32'h200, 16);
    data_in        = 32'hBEEF;
    data_in_valid  = 1'b1;
    data_out_ready = 1'b1;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 32'h201 || fifo_full !== 1'b1 || overflow_error !== 1'b0) begin
      errors++;
      $display("FAIL sim_full valid=%b data=%h f=%b ov=%b required 1 00000201 1 0", data_out_valid, data_out, fifo_full, overflow_error);
    end
    for (int j = 1; j <= 16; j++) begin
      tick();
      exp = (j < 16) ? 32'h201 + 32'(j) : 32'hBEEF;
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== exp) begin
        errors++;
        $display("FAIL sim_drain n=%0d valid=%b data=%h required valid=1 data=%h", j, data_out_valid, data_out, exp);
      end
    end
    data_out_ready = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL sim_empty e=%b required 1", fifo_empty);
    end
    data_in        = 32'h55;
    data_in_valid  = 1'b1;
    data_out_ready = 1'b1;
    tick();
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0 || fifo_empty !== 1'b0 || data_out !== 32'hBEEF) begin
      errors++;
      $display("FAIL sim_empty_pushpop valid=%b e=%b data=%h required valid=0 e=0 data=0000beef", data_out_valid, fifo_empty, data_out);
    end
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 32'h55 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL sim_single valid=%b data=%h e=%b required 1 00000055 1", data_out_valid, data_out, fifo_empty);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] q[$];
    logic [31:0] exp;
    logic [31:0] exp_cnt;
    int occ;
    int pushed;
    int popped;
    int c;
    bit pe;
    bit po;
    do_reset();
    occ    = 0;
    pushed = 0;
    popped = 0;
    c      = 0;
    while ((pushed < 40 || popped < 40) && c < 200) begin
      pe = (pushed < 40) && (occ < 7);
      po = (occ > 3 && ((c % 2) == 0 || occ == 7)) || (pushed == 40 && occ > 0);
      data_in        = 32'h300 + 32'(pushed);
      data_in_valid  = pe;
      data_out_ready = po;
      tick();
      if (pe) begin
        q.push_back(32'h300 + 32'(pushed));
        pushed++;
      end
      if (po) begin
        exp = q.pop_front();
        popped++;
        checks++;
        if (data_out_valid !== 1'b1 || data_out !== exp) begin
          errors++;
          $display("FAIL wrap_word n=%0d valid=%b data=%h required valid=1 data=%h", popped, data_out_valid, data_out, exp);
        end
      end else begin
        checks++;
        if (data_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL wrap_idle cycle=%0d valid=%b required 0", c, data_out_valid);
        end
      end
      occ = occ + int'(pe) - int'(po);
      c++;
    end
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    checks++;
    if (popped != 40 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done popped=%0d e=%b required popped=40 e=1", popped, fifo_empty);
    end
`ifdef GRAPH_DATA_FIFO_STATS_EN
    exp_cnt = 32'd40;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (push_count !== exp_cnt || pop_count !== exp_cnt) begin
      errors++;
      $display("FAIL wrap_stats push=%0d pop=%0d required %0d %0d", push_count, pop_count, exp_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    push_words(32'h400, 10);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 32'h401 || fifo_almost_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre valid=%b data=%h af=%b required 1 00000401 0", data_out_valid, data_out, fifo_almost_full);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== 32'h0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
        fifo_almost_full !== 1'b0 || overflow_error !== 1'b0 || push_count !== 32'd0 || pop_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset valid=%b data=%h e=%b f=%b af=%b ov=%b push=%0d pop=%0d required 0 0 1 0 0 0 0 0",
               data_out_valid, data_out, fifo_empty, fifo_full, fifo_almost_full, overflow_error, push_count, pop_count);
    end
    tick();
    rstn = 1'b1;
    tick();
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_pop valid=%b e=%b required valid=0 e=1", data_out_valid, fifo_empty);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rstn           = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
